// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: ALU opcode mnemonics and sequencer states.
// OP_MUL only triggers the multi-cycle path when ALU_SEQ_MUL_EN is defined.
package alu_sequencer_pkg;

  localparam int OPS_W = 4;

  typedef enum logic [OPS_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_GEQ = 4'h5,
    OP_EQ  = 4'h6,
    OP_NEQ = 4'h7,
    OP_MUL = 4'hF
  } op_mne_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2,
    MUL  = 2'd3
  } seq_state_t;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after the pointer, wrapping modulo NREQ.
module alu_sequencer_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[PW'(w_idx)]) begin
        o_grant[PW'(w_idx)] = 1'b1;
        w_found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Round-robin shares one external combinational ALU among NREQ requesters.
// Define ALU_SEQ_MUL_EN to add a W-iteration shift-add multiply built on ADD.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W    = 8,
  parameter int Ops  = 4,
  parameter int NREQ = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*Ops-1:0]     i_req_op,
  input  logic [NREQ*W-1:0]       i_req_a,
  input  logic [NREQ*W-1:0]       i_req_b,
  output logic [W-1:0]            o_alu_a,
  output logic [W-1:0]            o_alu_b,
  output logic [Ops-1:0]          o_alu_op,
  input  logic [W-1:0]            i_alu_out,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [W-1:0]            o_rsp_data,
  output logic [$clog2(NREQ)-1:0] o_rsp_id,
  output logic                    o_busy
);

  localparam int IW = $clog2(NREQ);

  seq_state_t        r_state;
  logic [IW-1:0]     r_ptr;
  logic [W-1:0]      r_alu_a;
  logic [W-1:0]      r_alu_b;
  logic [Ops-1:0]    r_alu_op;
  logic [W-1:0]      r_rsp_data;
  logic [IW-1:0]     r_rsp_id;
  logic              r_rsp_valid;
  logic              r_busy;

  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_gidx;
  logic              w_can_accept;
  logic              w_accept;
  logic [Ops-1:0]    w_sel_op;
  logic [W-1:0]      w_sel_a;
  logic [W-1:0]      w_sel_b;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  logic [W-1:0]      r_mp;
  logic [CW-1:0]     r_cnt;
  logic              w_is_mul;
  assign w_is_mul = (w_sel_op == Ops'(OP_MUL));
`endif

  alu_sequencer_rr_arbiter #(.NREQ(NREQ), .PW(IW)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Completing a response frees the slot in the same cycle, so no bubble.
  assign w_can_accept = (r_state == IDLE) || ((r_state == RESP) && i_rsp_ready);
  assign o_req_ready  = w_can_accept ? w_grant : '0;
  assign w_accept     = |(i_req_valid & o_req_ready);

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gidx = IW'(i);
    end
  end

  assign w_sel_op = i_req_op[w_gidx*Ops +: Ops];
  assign w_sel_a  = i_req_a[w_gidx*W +: W];
  assign w_sel_b  = i_req_b[w_gidx*W +: W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mp        <= '0;
      r_cnt       <= '0;
`endif
    end else if (w_accept) begin
      r_rsp_id    <= w_gidx;
      r_ptr       <= IW'(rr_next(int'(w_gidx), NREQ));
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      // alu_a doubles as the accumulator and alu_b as the shifting multiplicand.
      if (w_is_mul) begin
        r_alu_a  <= '0;
        r_alu_b  <= w_sel_a;
        r_alu_op <= Ops'(OP_ADD);
        r_mp     <= w_sel_b;
        r_cnt    <= '0;
        r_state  <= MUL;
      end else
`endif
      begin
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_op <= w_sel_op;
        r_state  <= EXEC;
      end
    end else begin
      case (r_state)
        EXEC: begin
          r_rsp_data  <= i_alu_out;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          if (r_mp[0]) r_alu_a <= i_alu_out;
          r_alu_b <= r_alu_b << 1;
          r_mp    <= r_mp >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_rsp_data  <= r_mp[0] ? i_alu_out : r_alu_a;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_valid = r_rsp_valid;
  assign o_busy      = r_busy;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Shares the single combinational ALU among NREQ requesters (fetch/execute units, debug port) through a round-robin arbiter with valid/ready handshakes.
- Registers the operands, drives the ALU and captures its result. Returns the result on a valid/ready response channel tagged with the requester ID.
- With the optional feature, sequences a multi-cycle shift-add multiply using the ALU's ADD operation.

Parameters:
- W, 8, datapath width; must equal the ALU W.
- Ops, 4, opcode width; must equal the ALU Ops.
- NREQ, 2, number of requesters; legal range 2..4.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
- req_op  in  NREQ*Ops  packed opcodes; requester i at [i*Ops +: Ops].
- req_a  in  NREQ*W  packed operand A.
- req_b  in  NREQ*W  packed operand B.
- alu_a  out  W  to ALU InputA, registered.
- alu_b  out  W  to ALU InputB, registered.
- alu_op  out  Ops  to ALU OP, registered.
- alu_out  in  W  from ALU Out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  W  result.
- rsp_id  out  $clog2(NREQ)  index of the requester that issued the operation.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (Reset low, async): state=IDLE. alu_a, alu_b, alu_op, rsp_data, rsp_id, rsp_valid and busy all = 0. RR pointer = 0, so requester 0 has priority first. An operation in progress at reset is aborted and produces no response.
- States: IDLE, EXEC, RESP, plus MUL with MUL_EN.
- IDLE:
  - req_ready = one-hot grant to the first valid requester at or after the RR pointer, wrapping modulo NREQ. No requester valid -> req_ready = 0.
  - On accept, register that requester's op, a and b into alu_op, alu_a and alu_b, and its index into rsp_id.
  - Set the RR pointer to (granted+1) mod NREQ.
  - Go to EXEC, or to MUL if op==MUL and MUL_EN is defined.
- EXEC: one cycle. rsp_data <= alu_out, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable until rsp_ready.
  - rsp_ready=1 completes the response. In that same cycle req_ready follows the IDLE arbitration rule (combinational on rsp_ready), so a new accept goes straight to EXEC/MUL with no bubble.
  - No new accept -> go to IDLE and clear rsp_valid.
- Latency: accept in cycle N -> rsp_valid high in cycle N+2 for single-pass ops. Sustained throughput is one operation per 2 cycles.
- Arbitration boundaries:
  - Only one grant per cycle.
  - A requester that drops req_valid before grant loses nothing; no state is kept for it.
  - All requesters valid continuously -> strict rotation 0,1,..,NREQ-1,0.
- Opcodes are passed to the ALU unmodified; results are the ALU's (e.g. GEQ/EQ/NEQ give 0 or 1).
- Widths: all arithmetic is modulo 2^W. Carries are discarded.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode MUL enters state MUL and runs W iterations with an internal counter, acc=0, mc=alu_a, mp=alu_b.
  - Each iteration drives ALU ADD with InputA=acc, InputB=mc. If mp[0], acc <= alu_out.
  - Each iteration also sets mc <= mc<<1 and mp <= mp>>1 internally.
  - After iteration W-1: rsp_data <= acc, rsp_valid <= 1, go to RESP.
  - Accept N -> rsp_valid at N+W+1. Result is the low W bits of the product.
- Undefined: MUL is not special; it is passed to the ALU like any other opcode. The ALU default yields rsp_data=0 at normal single-pass latency. MUL state, counter and acc/mc/mp registers are absent.

Decomposition:
- Package definitions:
  - existing op_mne enum plus new member MUL = 4'hF;
  - seq_state_t enum {IDLE, EXEC, RESP, MUL}.
- One natural sub-module, rr_arbiter: parameter NREQ; inputs req and pointer; output one-hot grant. Purely combinational.
- The ALU stays a separate instance wired externally.

Test Plan:
- Reset mid-EXEC with requester 0 ADD a=8'h05 b=8'h03 -> no rsp_valid ever for that op; all outputs 0 while Reset is low.
- Single ADD 8'hF0+8'h20 from requester 1, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_data=8'h10, rsp_id=1.
- Both requesters valid continuously, 6 ops, rsp_ready=1 -> grant order 0,1,0,1,0,1; back-to-back, one response every 2 cycles.
- rsp_ready held 0 for 5 cycles during RESP with EQ 8'h7A,8'h7A -> rsp_valid and rsp_data=8'h01 held stable, req_ready=0, then released on rsp_ready.
- ALU_SEQ_MUL_EN defined, MUL 8'd13*8'd11 -> rsp_data=8'h8F (143) at accept+9. Repeat with 8'd20*8'd20 -> 8'h90 (400 mod 256).
- ALU_SEQ_MUL_EN undefined, same MUL 13*11 -> rsp_data=8'h00 at accept+2.
